// File: rtl/obj_line_scheduler_pkg.sv
// rtl/obj_line_scheduler_pkg.sv - shared constants, descriptor layout and coordinate helpers for the object scheduler
package obj_line_scheduler_pkg;

  localparam logic [2:0] FLD_PIVOT_H = 3'd0;
  localparam logic [2:0] FLD_PIVOT_V = 3'd1;
  localparam logic [2:0] FLD_MEM_H   = 3'd2;
  localparam logic [2:0] FLD_MEM_V   = 3'd3;
  localparam logic [2:0] FLD_WIDTH   = 3'd4;
  localparam logic [2:0] FLD_HEIGHT  = 3'd5;
  localparam logic [2:0] FLD_ENABLE  = 3'd6;

  localparam logic [9:0] H_SCAN_START = 10'd640;
  localparam logic [9:0] H_LINE_END   = 10'd799;
  localparam logic [9:0] V_LAST       = 10'd524;

  localparam int SCALE_MUL   = 3;
  localparam int SCALE_SHIFT = 3;

  typedef struct packed {
    logic       en;
    logic [9:0] pivot_h;
    logic [9:0] pivot_v;
    logic [9:0] mem_h;
    logic [9:0] mem_v;
    logic [9:0] width;
    logic [9:0] height;
  } obj_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } sched_state_t;

  // Product kept wide enough for the whole blanking range so no column aliases.
  function automatic logic [9:0] scale_coord(input logic [9:0] c);
    logic [11:0] p;
    p = {2'b00, c} * 12'(SCALE_MUL);
    return 10'(p >> SCALE_SHIFT);
  endfunction

  // A zero span can never cover anything, which gives the width/height=0 rule for free.
  function automatic logic covers(input logic [9:0] c, input logic [9:0] base, input logic [9:0] span);
    return ({1'b0, c} >= {1'b0, base}) && ({1'b0, c} < ({1'b0, base} + {1'b0, span}));
  endfunction

endpackage

// File: rtl/obj_addr_calc.sv
// rtl/obj_addr_calc.sv - combinational logical-coordinate scaling and sprite-sheet address arithmetic
module obj_addr_calc
  import obj_line_scheduler_pkg::*;
#(
  parameter int MEM_W  = 240,
  parameter int ADDR_W = 16
) (
  input  logic [9:0]        i_vga_h,
  input  logic [9:0]        i_vga_v,
  output logic [9:0]        o_log_h,
  output logic [9:0]        o_log_v,
  input  logic [9:0]        i_h,
  input  logic [9:0]        i_v,
  input  logic [9:0]        i_pivot_h,
  input  logic [9:0]        i_pivot_v,
  input  logic [9:0]        i_mem_h,
  input  logic [9:0]        i_mem_v,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] w_tex_h;
  logic [ADDR_W-1:0] w_tex_v;

  assign o_log_h = scale_coord(i_vga_h);
  assign o_log_v = scale_coord(i_vga_v);

  assign w_tex_h = ADDR_W'(i_h) - ADDR_W'(i_pivot_h) + ADDR_W'(i_mem_h);
  assign w_tex_v = ADDR_W'(i_v) - ADDR_W'(i_pivot_v) + ADDR_W'(i_mem_v);
  assign o_addr  = w_tex_h + ADDR_W'(MEM_W) * w_tex_v;

endmodule

// File: rtl/obj_line_scheduler.sv
// rtl/obj_line_scheduler.sv - per-line object scheduler and pixel resolver sharing one sprite ROM port
// Optional OBJ_SCHED_OVF_CNT_EN adds ovf_lines, a per-frame count of overflowed lines.
module obj_line_scheduler
  import obj_line_scheduler_pkg::*;
#(
  parameter int NUM_OBJ  = 8,
  parameter int MAX_LINE = 4,
  parameter int MEM_W    = 240,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        vga_h,
  input  logic [9:0]        vga_v,
  input  logic              valid,
  input  logic              frame_cmt,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_idx,
  input  logic [2:0]        cfg_fld,
  input  logic [9:0]        cfg_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic [2:0]        obj_id,
  output logic              line_ovf
`ifdef OBJ_SCHED_OVF_CNT_EN
  ,
  output logic [7:0]        ovf_lines
`endif
);

  localparam int CNT_W  = $clog2(MAX_LINE + 1);
  localparam int SLOT_W = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;

  obj_desc_t    r_shadow   [NUM_OBJ];
  obj_desc_t    r_active   [NUM_OBJ];
  obj_desc_t    w_shadow_nx[NUM_OBJ];

  sched_state_t r_state;
  logic [2:0]   r_scan_idx;
  logic [2:0]   r_back_idx [MAX_LINE];
  logic [2:0]   r_front_idx[MAX_LINE];
  logic [CNT_W-1:0] r_back_cnt;
  logic [CNT_W-1:0] r_front_cnt;

  obj_desc_t    w_scan_desc;
  logic [9:0]   w_v_next;
  logic         w_scan_hit;
  logic         w_ovf_evt;

  // The copy on frame_cmt uses the post-write view so a same-cycle cfg_we is included.
  always_comb begin
    for (int i = 0; i < NUM_OBJ; i++) begin
      w_shadow_nx[i] = r_shadow[i];
    end
    if (cfg_we) begin
      case (cfg_fld)
        FLD_PIVOT_H: w_shadow_nx[cfg_idx].pivot_h = cfg_data;
        FLD_PIVOT_V: w_shadow_nx[cfg_idx].pivot_v = cfg_data;
        FLD_MEM_H:   w_shadow_nx[cfg_idx].mem_h   = cfg_data;
        FLD_MEM_V:   w_shadow_nx[cfg_idx].mem_v   = cfg_data;
        FLD_WIDTH:   w_shadow_nx[cfg_idx].width   = cfg_data;
        FLD_HEIGHT:  w_shadow_nx[cfg_idx].height  = cfg_data;
        FLD_ENABLE:  w_shadow_nx[cfg_idx].en      = cfg_data[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        r_shadow[i] <= w_shadow_nx[i];
        if (frame_cmt) r_active[i] <= w_shadow_nx[i];
      end
    end
  end

  assign w_v_next    = (vga_v == V_LAST) ? 10'd0 : scale_coord(vga_v + 10'd1);
  assign w_scan_desc = r_active[r_scan_idx];
  assign w_scan_hit  = w_scan_desc.en && (w_scan_desc.width != 10'd0) &&
                       covers(w_v_next, w_scan_desc.pivot_v, w_scan_desc.height);
  assign w_ovf_evt   = (r_state == ST_SCAN) && (vga_h != H_LINE_END) && w_scan_hit &&
                       (r_back_cnt == CNT_W'(MAX_LINE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_scan_idx  <= '0;
      r_back_cnt  <= '0;
      r_front_cnt <= '0;
      for (int s = 0; s < MAX_LINE; s++) begin
        r_back_idx[s]  <= '0;
        r_front_idx[s] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (vga_h == H_SCAN_START) begin
            r_state    <= ST_SCAN;
            r_scan_idx <= '0;
            r_back_cnt <= '0;
          end
        end
        ST_SCAN: begin
          // A scan overrun into the line end still hands over whatever was found.
          if (vga_h == H_LINE_END) begin
            r_front_idx <= r_back_idx;
            r_front_cnt <= r_back_cnt;
            r_state     <= ST_IDLE;
          end else begin
            if (w_scan_hit && (r_back_cnt < CNT_W'(MAX_LINE))) begin
              r_back_idx[r_back_cnt[SLOT_W-1:0]] <= r_scan_idx;
              r_back_cnt <= r_back_cnt + 1'b1;
            end
            if (r_scan_idx == 3'(NUM_OBJ - 1)) r_state <= ST_DONE;
            else r_scan_idx <= r_scan_idx + 3'd1;
          end
        end
        ST_DONE: begin
          if (vga_h == H_LINE_END) begin
            r_front_idx <= r_back_idx;
            r_front_cnt <= r_back_cnt;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) line_ovf <= 1'b0;
    else        line_ovf <= (line_ovf && !frame_cmt) || w_ovf_evt;
  end

`ifdef OBJ_SCHED_OVF_CNT_EN
  logic [7:0] r_ovf_cur;
  logic       r_line_counted;
  logic       w_line_new_ovf;

  assign w_line_new_ovf = w_ovf_evt && !r_line_counted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cur      <= '0;
      r_line_counted <= 1'b0;
      ovf_lines      <= '0;
    end else begin
      if (r_state == ST_IDLE && vga_h == H_SCAN_START) r_line_counted <= 1'b0;
      else if (w_line_new_ovf)                          r_line_counted <= 1'b1;
      if (frame_cmt) begin
        ovf_lines <= r_ovf_cur;
        r_ovf_cur <= w_line_new_ovf ? 8'd1 : 8'd0;
      end else if (w_line_new_ovf && r_ovf_cur != 8'hFF) begin
        r_ovf_cur <= r_ovf_cur + 8'd1;
      end
    end
  end
`endif

  logic [9:0]          w_log_h;
  logic [9:0]          w_log_v;
  obj_desc_t           w_slot_desc[MAX_LINE];
  logic [MAX_LINE-1:0] w_slot_hit;
  logic [9:0]          r_s1_h;
  logic [9:0]          r_s1_v;
  logic                r_s1_valid;
  logic [MAX_LINE-1:0] r_s1_hit;
  logic                w_win_found;
  logic [SLOT_W-1:0]   w_win_slot;
  obj_desc_t           w_win_desc;
  logic [ADDR_W-1:0]   w_addr;

  always_comb begin
    for (int s = 0; s < MAX_LINE; s++) begin
      w_slot_desc[s] = r_active[r_front_idx[s]];
      w_slot_hit[s]  = (CNT_W'(s) < r_front_cnt) && w_slot_desc[s].en &&
                       covers(w_log_h, w_slot_desc[s].pivot_h, w_slot_desc[s].width) &&
                       covers(w_log_v, w_slot_desc[s].pivot_v, w_slot_desc[s].height);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_h     <= '0;
      r_s1_v     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_hit   <= '0;
    end else begin
      r_s1_h     <= w_log_h;
      r_s1_v     <= w_log_v;
      r_s1_valid <= valid;
      r_s1_hit   <= w_slot_hit;
    end
  end

  // Slots hold indices in ascending order, so the lowest slot is the highest priority.
  always_comb begin
    w_win_found = 1'b0;
    w_win_slot  = '0;
    for (int s = MAX_LINE - 1; s >= 0; s--) begin
      if (r_s1_hit[s]) begin
        w_win_found = 1'b1;
        w_win_slot  = SLOT_W'(s);
      end
    end
  end

  assign w_win_desc = r_active[r_front_idx[w_win_slot]];

  obj_addr_calc #(
    .MEM_W (MEM_W),
    .ADDR_W(ADDR_W)
  ) u_addr_calc (
    .i_vga_h  (vga_h),
    .i_vga_v  (vga_v),
    .o_log_h  (w_log_h),
    .o_log_v  (w_log_v),
    .i_h      (r_s1_h),
    .i_v      (r_s1_v),
    .i_pivot_h(w_win_desc.pivot_h),
    .i_pivot_v(w_win_desc.pivot_v),
    .i_mem_h  (w_win_desc.mem_h),
    .i_mem_v  (w_win_desc.mem_v),
    .o_addr   (w_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en   <= 1'b0;
      mem_addr <= '0;
      obj_id   <= '0;
    end else begin
      mem_en   <= r_s1_valid && w_win_found;
      mem_addr <= (r_s1_valid && w_win_found) ? w_addr : '0;
      obj_id   <= (r_s1_valid && w_win_found) ? r_front_idx[w_win_slot] : 3'd0;
    end
  end

endmodule

// File: tb/tb_obj_line_scheduler.sv
// tb/tb_obj_line_scheduler.sv - directed self-checking bench for obj_line_scheduler
module tb_obj_line_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  vga_h;
  logic [9:0]  vga_v;
  logic        valid;
  logic        frame_cmt;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [2:0]  cfg_fld;
  logic [9:0]  cfg_data;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic [2:0]  obj_id;
  logic        line_ovf;
`ifdef OBJ_SCHED_OVF_CNT_EN
  logic [7:0]  ovf_lines;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  obj_line_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vga_h    (vga_h),
    .vga_v    (vga_v),
    .valid    (valid),
    .frame_cmt(frame_cmt),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_fld  (cfg_fld),
    .cfg_data (cfg_data),
    .mem_addr (mem_addr),
    .mem_en   (mem_en),
    .obj_id   (obj_id),
    .line_ovf (line_ovf)
`ifdef OBJ_SCHED_OVF_CNT_EN
    ,
    .ovf_lines(ovf_lines)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input int fld, input int data);
    cfg_we   = 1'b1;
    cfg_idx  = 3'(idx);
    cfg_fld  = 3'(fld);
    cfg_data = 10'(data);
    @(posedge clk); #1;
    cfg_we   = 1'b0;
  endtask

  task automatic set_obj(input int idx, input int ph, input int pv, input int mh, input int mv,
                         input int w, input int h, input int en);
    wr(idx, 0, ph);
    wr(idx, 1, pv);
    wr(idx, 2, mh);
    wr(idx, 3, mv);
    wr(idx, 4, w);
    wr(idx, 5, h);
    wr(idx, 6, en);
  endtask

  task automatic commit();
    frame_cmt = 1'b1;
    @(posedge clk); #1;
    frame_cmt = 1'b0;
  endtask

  // Walk the blanking interval of the preceding line so the scan builds this line's list.
  task automatic prep(input int prev_v);
    valid = 1'b0;
    vga_v = 10'(prev_v);
    for (int h = 640; h <= 799; h++) begin
      vga_h = 10'(h);
      @(posedge clk); #1;
    end
  endtask

  task automatic pix(input int h, input int v, input logic vld);
    vga_h = 10'(h);
    vga_v = 10'(v);
    valid = vld;
    repeat (2) @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; vga_h = '0; vga_v = '0; valid = 1'b0; frame_cmt = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_fld = '0; cfg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_obj_id", 32'(obj_id), 0);
    check("rst_line_ovf", 32'(line_ovf), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single object: logical (12,21) -> texel (2,1) -> 2 + 240
    set_obj(0, 10, 20, 0, 0, 16, 16, 1);
    commit();
    prep(55);
    pix(32, 56, 1'b1);
    check("t1_mem_en", 32'(mem_en), 1);
    check("t1_obj_id", 32'(obj_id), 0);
    check("t1_mem_addr", 32'(mem_addr), 242);
    pix(32, 56, 1'b0);
    check("t1_novalid_en", 32'(mem_en), 0);
    check("t1_novalid_addr", 32'(mem_addr), 0);

    // Priority between overlapping objects
    wr(0, 6, 0);
    set_obj(1, 10, 20, 0, 0, 16, 16, 1);
    set_obj(3, 12, 20, 5, 2, 16, 16, 1);
    commit();
    prep(55);
    pix(32, 56, 1'b1);
    check("t2_prio_id", 32'(obj_id), 1);
    check("t2_prio_addr", 32'(mem_addr), 242);
    wr(1, 6, 0);
    commit();
    prep(55);
    pix(32, 56, 1'b1);
    check("t2_obj3_id", 32'(obj_id), 3);
    check("t2_obj3_addr", 32'(mem_addr), 725);

    // Five objects on one line: only the first four are listed
    for (int k = 0; k < 5; k++) set_obj(k, 40 * k, 20, 0, 0, 16, 16, 1);
    commit();
    prep(55);
    check("t3_ovf_set", 32'(line_ovf), 1);
    pix(6, 56, 1'b1);
    check("t3_obj0_id", 32'(obj_id), 0);
    check("t3_obj0_addr", 32'(mem_addr), 242);
    pix(326, 56, 1'b1);
    check("t3_obj3_en", 32'(mem_en), 1);
    check("t3_obj3_id", 32'(obj_id), 3);
    pix(432, 56, 1'b1);
    check("t3_obj4_dropped", 32'(mem_en), 0);
    commit();
    check("t3_ovf_clear", 32'(line_ovf), 0);

    // Write coinciding with commit is taken; write without commit is not
    wr(0, 6, 0); wr(1, 6, 0); wr(3, 6, 0); wr(4, 6, 0);
    commit();
    cfg_we = 1'b1; cfg_idx = 3'd2; cfg_fld = 3'd0; cfg_data = 10'd100;
    frame_cmt = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; frame_cmt = 1'b0;
    prep(55);
    pix(272, 56, 1'b1);
    check("t4_new_pivot_id", 32'(obj_id), 2);
    check("t4_new_pivot_addr", 32'(mem_addr), 242);
    pix(219, 56, 1'b1);
    check("t4_old_pivot_gone", 32'(mem_en), 0);
    wr(2, 0, 50);
    prep(55);
    pix(272, 56, 1'b1);
    check("t4_uncommitted_en", 32'(mem_en), 1);
    check("t4_uncommitted_addr", 32'(mem_addr), 242);

    // Zero-sized objects never draw; last line schedules logical line 0
    wr(2, 5, 0);
    commit();
    prep(55);
    pix(139, 56, 1'b1);
    check("t5_height0", 32'(mem_en), 0);
    wr(2, 5, 16);
    wr(2, 4, 0);
    commit();
    prep(55);
    pix(139, 56, 1'b1);
    check("t5_width0", 32'(mem_en), 0);
    set_obj(0, 10, 0, 0, 0, 16, 16, 1);
    wr(2, 6, 0);
    commit();
    prep(524);
    pix(32, 0, 1'b1);
    check("t5_wrap_en", 32'(mem_en), 1);
    check("t5_wrap_addr", 32'(mem_addr), 2);

    // Asynchronous reset while the scan is running
    set_obj(1, 235, 0, 0, 0, 16, 16, 1);
    commit();
    prep(524);
    vga_v = 10'd0;
    valid = 1'b1;
    for (int h = 640; h <= 642; h++) begin
      vga_h = 10'(h);
      @(posedge clk); #1;
    end
    check("t6_pre_en", 32'(mem_en), 1);
    check("t6_pre_id", 32'(obj_id), 1);
    check("t6_pre_addr", 32'(mem_addr), 5);
    rst_n = 1'b0;
    #1;
    check("t6_rst_en", 32'(mem_en), 0);
    check("t6_rst_id", 32'(obj_id), 0);
    check("t6_rst_addr", 32'(mem_addr), 0);
    check("t6_rst_ovf", 32'(line_ovf), 0);
    valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    prep(524);
    pix(32, 0, 1'b1);
    check("t6_post_obj0", 32'(mem_en), 0);
    pix(652, 0, 1'b1);
    check("t6_post_obj1", 32'(mem_en), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
